// File: rtl/sobel_window_ctrl.sv
// Window sequencer for the Sobel vertical-gradient stage: buffers two rows of a
// raster pixel stream and presents each interior 3x3 neighbourhood under valid/ready.
module sobel_window_ctrl #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int PIX_W = 8
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             frame_start,
  input  logic [PIX_W-1:0] pix_in,
  input  logic             pix_valid,
  output logic             pix_ready,
  output logic [PIX_W-1:0] P0,
  output logic [PIX_W-1:0] P1,
  output logic [PIX_W-1:0] P2,
  output logic [PIX_W-1:0] P3,
  output logic [PIX_W-1:0] P4,
  output logic [PIX_W-1:0] P5,
  output logic [PIX_W-1:0] P6,
  output logic [PIX_W-1:0] P7,
  output logic [PIX_W-1:0] P8,
  output logic             start_calculations,
  input  logic             win_ready,
  output logic [15:0]      win_x,
  output logic [15:0]      win_y,
  output logic             busy,
  output logic             frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_STREAM, S_DONE} state_t;

  localparam int          AW       = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [15:0] LAST_COL = 16'(IMG_W - 1);
  localparam logic [15:0] LAST_ROW = 16'(IMG_H - 1);

  state_t r_state, w_state_nxt;

  logic [PIX_W-1:0] r_lbuf1 [IMG_W];
  logic [PIX_W-1:0] r_lbuf2 [IMG_W];
  logic [PIX_W-1:0] r_win   [9];
  logic [15:0]      r_col, r_row, r_win_x, r_win_y;
  logic             r_sc, r_last;

  logic          w_accept, w_win_acc, w_completes;
  logic [AW-1:0] w_idx;

  assign w_idx       = r_col[AW-1:0];
  // r_last blocks further pixels between the final accept and its window handshake.
  assign pix_ready   = ((r_state == S_PRIME) || (r_state == S_STREAM)) &&
                       (!r_sc || win_ready) && !r_last;
  assign w_accept    = pix_valid && pix_ready;
  assign w_win_acc   = r_sc && win_ready;
  assign w_completes = (r_row >= 16'd2) && (r_col >= 16'd2);

  assign start_calculations = r_sc;
  assign win_x      = r_win_x;
  assign win_y      = r_win_y;
  assign busy       = (r_state != S_IDLE);
  assign frame_done = (r_state == S_DONE);

  assign P0 = r_win[0];
  assign P1 = r_win[1];
  assign P2 = r_win[2];
  assign P3 = r_win[3];
  assign P4 = r_win[4];
  assign P5 = r_win[5];
  assign P6 = r_win[6];
  assign P7 = r_win[7];
  assign P8 = r_win[8];

  // NOTE: state and datapath registers use non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: next state defaults to the current state first, so no path through
  // this block leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    if (frame_start) begin
      w_state_nxt = S_PRIME;
    end else begin
      case (r_state)
        S_IDLE: w_state_nxt = S_IDLE;
        S_PRIME, S_STREAM: begin
          if (r_last && w_win_acc) w_state_nxt = S_DONE;
          else if (w_accept)       w_state_nxt = w_completes ? S_STREAM : S_PRIME;
        end
        S_DONE:  w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // NOTE: the line buffers and window are cleared in reset so a frame after
  // reset never exposes stale pixel data; this makes them flops, not RAM.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_col   <= '0;
      r_row   <= '0;
      r_win_x <= '0;
      r_win_y <= '0;
      r_sc    <= 1'b0;
      r_last  <= 1'b0;
      for (int i = 0; i < 9; i++) r_win[i] <= '0;
      for (int i = 0; i < IMG_W; i++) begin
        r_lbuf1[i] <= '0;
        r_lbuf2[i] <= '0;
      end
    end else if (frame_start) begin
      r_col  <= '0;
      r_row  <= '0;
      r_sc   <= 1'b0;
      r_last <= 1'b0;
    end else begin
      if (r_state == S_DONE) r_last <= 1'b0;
      if (w_win_acc)         r_sc   <= 1'b0;
      if (w_accept) begin
        r_win[0] <= r_win[1];
        r_win[1] <= r_win[2];
        r_win[2] <= r_lbuf2[w_idx];
        r_win[3] <= r_win[4];
        r_win[4] <= r_win[5];
        r_win[5] <= r_lbuf1[w_idx];
        r_win[6] <= r_win[7];
        r_win[7] <= r_win[8];
        r_win[8] <= pix_in;
        r_lbuf2[w_idx] <= r_lbuf1[w_idx];
        r_lbuf1[w_idx] <= pix_in;
        // A same-cycle handshake is overridden here by the next window.
        if (w_completes) begin
          r_sc    <= 1'b1;
          r_win_x <= r_col - 16'd1;
          r_win_y <= r_row - 16'd1;
        end
        if (r_col == LAST_COL) begin
          r_col <= '0;
          if (r_row == LAST_ROW) begin
            r_row  <= '0;
            r_last <= 1'b1;
          end else begin
            r_row <= r_row + 16'd1;
          end
        end else begin
          r_col <= r_col + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Directed bench for sobel_window_ctrl: a 4x4 instance for streaming, stall, abort
// and reset cases, and a 3x3 instance for the minimum image size.
module tb_sobel_window_ctrl;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       frame_start = 1'b0;
  logic       pix_valid = 1'b0;
  logic       win_ready = 1'b0;
  logic [7:0] pix_in = 8'd0;

  logic       a_pix_ready, a_sc, a_busy, a_frame_done;
  logic [7:0] a_p0, a_p1, a_p2, a_p3, a_p4, a_p5, a_p6, a_p7, a_p8;
  logic [15:0] a_win_x, a_win_y;
  logic       b_pix_ready, b_sc, b_busy, b_frame_done;
  logic [7:0] b_p0, b_p1, b_p2, b_p3, b_p4, b_p5, b_p6, b_p7, b_p8;
  logic [15:0] b_win_x, b_win_y;

  logic [71:0] a_win, b_win;
  assign a_win = {a_p0, a_p1, a_p2, a_p3, a_p4, a_p5, a_p6, a_p7, a_p8};
  assign b_win = {b_p0, b_p1, b_p2, b_p3, b_p4, b_p5, b_p6, b_p7, b_p8};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sobel_window_ctrl #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u_dut4 (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(a_pix_ready),
    .P0(a_p0), .P1(a_p1), .P2(a_p2), .P3(a_p3), .P4(a_p4),
    .P5(a_p5), .P6(a_p6), .P7(a_p7), .P8(a_p8),
    .start_calculations(a_sc), .win_ready(win_ready),
    .win_x(a_win_x), .win_y(a_win_y), .busy(a_busy), .frame_done(a_frame_done)
  );

  sobel_window_ctrl #(.IMG_W(3), .IMG_H(3), .PIX_W(8)) u_dut3 (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start), .pix_in(pix_in),
    .pix_valid(pix_valid), .pix_ready(b_pix_ready),
    .P0(b_p0), .P1(b_p1), .P2(b_p2), .P3(b_p3), .P4(b_p4),
    .P5(b_p5), .P6(b_p6), .P7(b_p7), .P8(b_p8),
    .start_calculations(b_sc), .win_ready(win_ready),
    .win_x(b_win_x), .win_y(b_win_y), .busy(b_busy), .frame_done(b_frame_done)
  );

  task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pixel value equals its raster index, so a window is fixed by its centre value c.
  function automatic logic [71:0] exp_win(input int c, input int w);
    logic [71:0] v;
    v = {8'(c-w-1), 8'(c-w), 8'(c-w+1), 8'(c-1), 8'(c), 8'(c+1), 8'(c+w-1), 8'(c+w), 8'(c+w+1)};
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    pix_valid   = 1'b0;
    tick();
    frame_start = 1'b0;
  endtask

  // Streams pixels 0..15 into the 4x4 instance and checks every presented window.
  task automatic run_stream(input string name, input bit toggle, input int stall_win,
                            input int stall_len, input int abort_at);
    int pix_idx = 0, n_win = 0, n_done = 0, stall_left = stall_len;
    int last_hs = -10, cyc = 0, after_done = 0;
    bit aborted = 1'b0, fin = 1'b0;
    int ex, ey;
    while (!fin) begin
      frame_start = 1'b0;
      if (abort_at > 0 && !aborted && pix_idx == abort_at) begin
        frame_start = 1'b1;
        pix_valid   = 1'b0;
        aborted     = 1'b1;
        pix_idx     = 0;
      end else begin
        pix_valid = (pix_idx < 16) && (!toggle || (cyc % 2 == 0));
      end
      pix_in = 8'(pix_idx);
      if (a_sc && n_win == stall_win && stall_left > 0) begin
        win_ready = 1'b0;
        stall_left--;
      end else begin
        win_ready = 1'b1;
      end
      @(negedge clk);
      if (!win_ready) check({name, " stall pix_ready"}, 72'(a_pix_ready), 72'(0));
      if (a_sc) begin
        ex = 1 + n_win % 2;
        ey = 1 + n_win / 2;
        check({name, " win_x"}, 72'(a_win_x), 72'(ex));
        check({name, " win_y"}, 72'(a_win_y), 72'(ey));
        check({name, " window"}, a_win, exp_win(ey * 4 + ex, 4));
        if (win_ready) begin
          n_win++;
          last_hs = cyc;
        end
      end
      if (a_frame_done) begin
        n_done++;
        check({name, " frame_done timing"}, 72'(cyc), 72'(last_hs + 1));
      end
      if (pix_valid && a_pix_ready) pix_idx++;
      if (n_done > 0) after_done++;
      cyc++;
      if (after_done == 3) fin = 1'b1;
      if (cyc >= 200) begin
        check({name, " timeout"}, 72'(after_done), 72'(3));
        fin = 1'b1;
      end
      tick();
    end
    pix_valid   = 1'b0;
    frame_start = 1'b0;
    check({name, " window count"}, 72'(n_win), 72'(4));
    check({name, " frame_done count"}, 72'(n_done), 72'(1));
    check({name, " pixels consumed"}, 72'(pix_idx), 72'(16));
    check({name, " busy after frame"}, 72'(a_busy), 72'(0));
  endtask

  initial begin
    int acc, n_win, n_done, cyc;

    // Reset state
    tick();
    check("reset window", a_win, 72'(0));
    check("reset outputs", 72'({a_pix_ready, a_sc, a_busy, a_frame_done}), 72'(0));
    check("reset coords", 72'({a_win_x, a_win_y}), 72'(0));
    n_rst = 1'b1;
    pix_valid = 1'b1;
    tick();
    @(negedge clk);
    check("idle pix_ready", 72'(a_pix_ready), 72'(0));
    check("idle busy", 72'(a_busy), 72'(0));
    tick();

    // T1 continuous stream
    pulse_start();
    check("T1 busy after start", 72'(a_busy), 72'(1));
    run_stream("T1", 1'b0, -1, 0, 0);

    // T2 three-cycle stall on the second window
    pulse_start();
    run_stream("T2", 1'b0, 1, 3, 0);

    // T3 pix_valid toggling every cycle
    pulse_start();
    run_stream("T3", 1'b1, -1, 0, 0);

    // T4 abort after pixel 9 has been accepted
    pulse_start();
    run_stream("T4", 1'b0, -1, 0, 10);

    // T5 reset after pixel 7
    pulse_start();
    acc = 0;
    cyc = 0;
    win_ready = 1'b1;
    while (acc < 8 && cyc < 50) begin
      pix_valid = 1'b1;
      pix_in    = 8'(acc);
      @(negedge clk);
      if (a_pix_ready) acc++;
      cyc++;
      tick();
    end
    check("T5 pixels before reset", 72'(acc), 72'(8));
    pix_valid = 1'b1;
    n_rst = 1'b0;
    #1;
    check("T5 reset window", a_win, 72'(0));
    check("T5 reset outputs", 72'({a_pix_ready, a_sc, a_busy, a_frame_done}), 72'(0));
    check("T5 reset coords", 72'({a_win_x, a_win_y}), 72'(0));
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("T5 pix_ready idle", 72'(a_pix_ready), 72'(0));
      check("T5 busy idle", 72'(a_busy), 72'(0));
    end
    tick();

    // T6 minimum 3x3 image on the second instance
    pulse_start();
    acc = 0;
    n_win = 0;
    n_done = 0;
    cyc = 0;
    win_ready = 1'b1;
    while (cyc < 20) begin
      pix_valid = (acc < 9);
      pix_in    = 8'(acc);
      @(negedge clk);
      if (b_sc) begin
        check("T6 win_x", 72'(b_win_x), 72'(1));
        check("T6 win_y", 72'(b_win_y), 72'(1));
        check("T6 window", b_win, exp_win(4, 3));
        n_win++;
      end
      if (b_frame_done) n_done++;
      if (pix_valid && b_pix_ready) acc++;
      cyc++;
      tick();
    end
    pix_valid = 1'b0;
    check("T6 window count", 72'(n_win), 72'(1));
    check("T6 frame_done count", 72'(n_done), 72'(1));
    check("T6 busy after frame", 72'(b_busy), 72'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
